nanov_instr_fetch: RTL

Bit-serial instruction fetch stage that sits directly upstream of the nanoV ALU/register datapath. It reads RV32E instructions from an external SPI NOR flash with the standard READ (0x03) command and presents one complete 32-bit instruction word, plus its address, to the core. The core consumes a word through a valid/ready handshake, and the fetch stage prefetches the next sequential word while the current one executes. A jump restarts the flash transaction at a new address.

---
 rtl/nanov_pkg.sv | 9 +
 rtl/nanov_instr_fetch_if.sv | 17 +
 rtl/nanov_spi_shifter.sv | 44 ++++
 rtl/nanov_instr_fetch.sv | 55 +++++
 4 files changed

// File: rtl/nanov_pkg.sv
// nanov_pkg: shared constants, state type and helpers for the nanoV fetch stage
package nanov_pkg;
  localparam int DEF_ADDR_W = 24;
  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  typedef enum logic [2:0] {IDLE, RESTART, CMD, ADDR, DATA, STALL} fetch_state_t;
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/nanov_instr_fetch_if.sv
// nanov_instr_fetch_if: core-side fetch handshake plus SPI flash pins
interface nanov_instr_fetch_if import nanov_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_addr;
  logic              instr_valid;
  logic              instr_ready;
  logic              spi_cs_n;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  modport master(input jump, jump_addr, instr_ready, spi_miso,
                 output instr, instr_addr, instr_valid, spi_cs_n, spi_clk, spi_mosi);
  modport slave(output jump, jump_addr, instr_ready, spi_miso,
                input instr, instr_addr, instr_valid, spi_cs_n, spi_clk, spi_mosi);
endinterface

// File: rtl/nanov_spi_shifter.sv
// nanov_spi_shifter: SPI bit phase/counter, command+address shift-out, data shift-in
module nanov_spi_shifter import nanov_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              stall,
  input  logic [5:0]        last,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              done,
  output logic [31:0]       word
);
  localparam int SW = 8 + ADDR_W;
  logic [SW-1:0] sout;
  logic [31:0]   sin;
  logic [5:0]    cnt;
  logic          step;
  assign step = en && !stall && sclk;
  assign done = step && cnt == last;
  assign mosi = sout[SW-1];
  // on the completing edge the last bit is still on miso, so fold it in
  assign word = bswap32(step ? {sin[30:0], miso} : sin);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sclk <= 1'b0;
      sout <= '0;
      sin  <= '0;
      cnt  <= '0;
    end else if (load) begin
      sclk <= 1'b0;
      sout <= {SPI_CMD_READ, load_addr};
      cnt  <= '0;
    end else if (en && !stall) begin
      sclk <= !sclk;
      if (sclk) begin
        sout <= {sout[SW-2:0], 1'b0};
        sin  <= {sin[30:0], miso};
        cnt  <= done ? '0 : cnt + 6'd1;
      end
    end
endmodule

// File: rtl/nanov_instr_fetch.sv
// nanov_instr_fetch: SPI NOR READ-command instruction fetch with a one-word output
// register; the shifter keeps prefetching while that register is occupied.
module nanov_instr_fetch import nanov_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W) (
  input  logic                clk,
  input  logic                rst,
  nanov_instr_fetch_if.master bus
);
  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] fetch_addr, jump_base;
  logic [31:0]       word;
  logic [5:0]        last;
  logic              done, hs, free, take, en, stall;
  assign jump_base = bus.jump_addr & ~ADDR_W'(3);
  assign hs        = bus.instr_valid && bus.instr_ready;
  assign free      = !bus.instr_valid || hs;
  always_comb begin
    en      = state inside {CMD, ADDR, DATA, STALL};
    stall   = state == STALL;
    last    = state == CMD ? 6'd7 : state == ADDR ? 6'(ADDR_W - 1) : 6'd31;
    take    = !bus.jump && free && ((state == DATA && done) || stall);
    state_n = bus.jump                      ? RESTART :
              state == RESTART              ? CMD     :
              state == CMD && done          ? ADDR    :
              state == ADDR && done         ? DATA    :
              state == DATA && done && !free ? STALL  :
              stall && free                 ? DATA    : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.instr       <= '0;
      bus.instr_addr  <= '0;
      bus.instr_valid <= 1'b0;
      bus.spi_cs_n    <= 1'b1;
      fetch_addr      <= '0;
    end else begin
      bus.spi_cs_n <= state_n inside {IDLE, RESTART};
      if (bus.jump) begin
        bus.instr_valid <= 1'b0;
        fetch_addr      <= jump_base;
      end else if (take) begin
        bus.instr       <= word;
        bus.instr_addr  <= fetch_addr;
        bus.instr_valid <= 1'b1;
        fetch_addr      <= fetch_addr + ADDR_W'(4);
      end else if (hs) bus.instr_valid <= 1'b0;
    end
  nanov_spi_shifter #(.ADDR_W(ADDR_W)) u_shift (
    .clk(clk), .rst(rst), .load(bus.jump), .en(en), .stall(stall), .last(last),
    .load_addr(jump_base), .miso(bus.spi_miso), .sclk(bus.spi_clk), .mosi(bus.spi_mosi),
    .done(done), .word(word)
  );
endmodule
